// File: rtl/instr_dispatch_queue.sv
// In-order instruction dispatch queue: circular buffer feeding add/sub and
// mul/div reservation stations, with a registered dispatch port and stall counter.
module instr_dispatch_queue #(
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 8,
  parameter int AF_MARGIN = 2
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     Push,
  input  logic [WIDTH-1:0]         Push_Instr,
  input  logic                     Pop,
  input  logic                     Flush,
  input  logic                     RS_Add_Full,
  input  logic                     RS_Mul_Full,
  output logic                     Push_Ready,
  output logic                     Dispatch_Valid,
  output logic [WIDTH-1:0]         Dispatch_Instr,
  output logic                     Dispatch_Class,
  output logic [$clog2(DEPTH):0]   Count,
  output logic                     Empty,
  output logic                     Full,
  output logic                     Almost_Full,
  output logic [15:0]              Stall_Count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(DEPTH - AF_MARGIN);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [CW-1:0]    count;

  logic [WIDTH-1:0] head_instr;
  logic             head_class;
  logic             target_full;
  logic             fire;
  logic             blocked;
  logic             push_ok;

  // Status flags come only from the registered count.
  assign Count       = count;
  assign Empty       = (count == '0);
  assign Full        = (count == DEPTH_C);
  assign Almost_Full = (count >= AF_C);
  assign Push_Ready  = (count < DEPTH_C);

  // Class is opcode bit 1: ADD/SUB -> 0, MUL/DIV -> 1.
  always_comb begin
    head_instr  = mem[head];
    head_class  = head_instr[WIDTH-3];
    target_full = head_class ? RS_Mul_Full : RS_Add_Full;
    fire        = Pop & ~Empty & ~Flush & ~target_full;
    blocked     = Pop & ~Empty & ~Flush & target_full;
    push_ok     = Push & ~Flush & ~Full;
  end

  always_ff @(posedge Clock) begin
    if (push_ok) begin
      mem[tail] <= Push_Instr;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset || Flush) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      if (push_ok) begin
        tail <= tail + 1'b1;
      end
      if (fire) begin
        head <= head + 1'b1;
      end
      case ({push_ok, fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Flush clears the valid pulse but leaves the last dispatched word visible.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      Dispatch_Valid <= 1'b0;
      Dispatch_Instr <= '0;
      Dispatch_Class <= 1'b0;
    end else begin
      Dispatch_Valid <= fire;
      if (fire) begin
        Dispatch_Instr <= head_instr;
        Dispatch_Class <= head_class;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      Stall_Count <= '0;
    end else if (blocked && (Stall_Count != '1)) begin
      Stall_Count <= Stall_Count + 1'b1;
    end
  end

endmodule
